stream_accumulator: RTL and testbench
=====================================

Name: stream_accumulator

Overview:
- Val/rdy stream stage that receives framed 32-bit messages from crossbar output port 1 and returns a result to crossbar input port 1.
- Sits beside the existing adder stage, so the Wishbone host can select it through the crossbar control.
- Each frame is one header word giving a word count N, followed by N data words.
- The block returns one word per frame: the modular sum of the N data words.

Parameters:
- BIT_WIDTH, 32, width of stream data and of the accumulator.
- COUNT_WIDTH, 8, number of header LSBs used as word count N; must satisfy COUNT_WIDTH <= BIT_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, release is synchronous to clk.
- i_stream_val  input  1  upstream word valid.
- i_stream_data  input  BIT_WIDTH  upstream word (header or data).
- i_stream_rdy  output  1  block can accept a word this cycle.
- o_stream_val  output  1  result word valid.
- o_stream_data  output  BIT_WIDTH  frame sum.
- o_stream_rdy  input  1  downstream accepts the result.

Behaviour:
- Handshakes:
  - An input transfer occurs on a rising edge with i_stream_val && i_stream_rdy.
  - An output transfer occurs on a rising edge with o_stream_val && o_stream_rdy.
  - No combinational path from any input to any output; all outputs are decoded from registers only.
- Reset (reset=0, any state, including mid-frame):
  - state=IDLE, sum=0, remaining=0.
  - i_stream_rdy=0 while reset is low; o_stream_val=0; o_stream_data=0.
  - Any partial frame is discarded; no result is emitted for it.
- State IDLE:
  - i_stream_rdy=1, o_stream_val=0.
  - On input transfer, the word is a header:
    - N = i_stream_data[COUNT_WIDTH-1:0]; upper bits are ignored.
    - Load remaining=N and sum=0.
    - If N==0, go to SEND with sum=0. Otherwise go to ACCUM.
- State ACCUM:
  - i_stream_rdy=1.
  - On input transfer: sum <= sum + i_stream_data, truncated to BIT_WIDTH (wrap-around, no saturation, carry dropped); remaining <= remaining-1.
  - On the transfer where remaining==1, go to SEND. The registered sum including that last word drives o_stream_data.
  - No transfer: hold all state.
- State SEND:
  - i_stream_rdy=0, o_stream_val=1, o_stream_data=sum.
  - o_stream_data stays stable while o_stream_val && !o_stream_rdy.
  - On output transfer, go to IDLE. sum is not cleared; o_stream_data may keep its value, but o_stream_val drops.
- Latency and throughput:
  - Last data word accepted at edge t gives o_stream_val=1 after edge t; the earliest output transfer is at edge t+1.
  - Header with N=0 at edge t gives a result of 0 valid after edge t.
  - After the output transfer at edge u, i_stream_rdy=1 after edge u, so the next header can be accepted at edge u+1.
  - Frame cost is therefore N+2 cycles minimum (header + N data + result).
- Boundaries:
  - N = 2^COUNT_WIDTH-1 (255) is supported; remaining must not underflow.
  - Words presented while i_stream_rdy=0 are not consumed; upstream holds them.
  - i_stream_val low mid-frame stalls indefinitely without state loss.
  - o_stream_rdy held low holds SEND indefinitely.
- Counters: remaining is COUNT_WIDTH bits; sum is BIT_WIDTH bits.

Test Plan:
- Basic frame: header 3, data 5, 7, 9, o_stream_rdy=1 -> one output 0x00000015 (21), valid one cycle after the last data word; i_stream_rdy=0 during SEND.
- Wrap: header 2, data 0xFFFFFFFF, 0x00000003 -> output 0x00000002. Header 0xABCD0001 -> N=1 (upper bits ignored); data 0x10 -> output 0x10.
- Zero count: header 0 -> output 0x00000000 after one cycle; the next header is accepted the cycle after the output transfer.
- Backpressure and stalls:
  - Header 2, data 1, 2 with i_stream_val gaps; o_stream_rdy held low for 4 cycles -> o_stream_data=3 stable throughout, exactly one transfer.
  - i_stream_rdy=0 for all of those SEND cycles.
- Reset mid-frame: header 4, data 10, 20, assert reset=0 asynchronously between edges -> outputs clear immediately. After release, header 1, data 7 -> output 7 (not 37).
- Back-to-back max frame: header 255 with data all 1, then header 1 with data 0x55 -> outputs 0x000000FF then 0x00000055, in order, no extra outputs.

Source files
------------

// File: rtl/stream_accumulator.sv
// Frame summing stream stage: a header word gives a count N, the next N words
// are added modulo 2^BIT_WIDTH, and one result word is returned per frame.
module stream_accumulator #(
   parameter int BIT_WIDTH   = 32,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_stream_val,
   input  logic [BIT_WIDTH-1:0] i_stream_data,
   output logic                 i_stream_rdy,
   output logic                 o_stream_val,
   output logic [BIT_WIDTH-1:0] o_stream_data,
   input  logic                 o_stream_rdy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [BIT_WIDTH-1:0]   r_sum;
   logic [BIT_WIDTH-1:0]   w_sum_next;
   logic [COUNT_WIDTH-1:0] r_remaining;
   logic [COUNT_WIDTH-1:0] w_remaining_next;
   logic [COUNT_WIDTH-1:0] w_hdr_count;
   logic                   r_in_rdy;
   logic                   r_out_val;
   logic                   w_in_xfer;
   logic                   w_out_xfer;

   // Handshakes use the registered flags so they match what the neighbours see.
   assign w_in_xfer   = i_stream_val && r_in_rdy;
   assign w_out_xfer  = r_out_val && o_stream_rdy;
   assign w_hdr_count = i_stream_data[COUNT_WIDTH-1:0];

   always_comb begin
      w_state_next     = r_state;
      w_sum_next       = r_sum;
      w_remaining_next = r_remaining;
      case (r_state)
         IDLE: begin
            if (w_in_xfer) begin
               w_remaining_next = w_hdr_count;
               w_sum_next       = '0;
               w_state_next     = (w_hdr_count == '0) ? SEND : ACCUM;
            end
         end
         ACCUM: begin
            if (w_in_xfer) begin
               w_sum_next       = r_sum + i_stream_data;
               w_remaining_next = r_remaining - COUNT_WIDTH'(1);
               if (r_remaining == COUNT_WIDTH'(1)) begin
                  w_state_next = SEND;
               end
            end
         end
         SEND: begin
            if (w_out_xfer) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Ready/valid are flopped from the next state so reset forces both low
   // without any path from an input pin to an output pin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_sum       <= '0;
         r_remaining <= '0;
         r_in_rdy    <= 1'b0;
         r_out_val   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sum       <= w_sum_next;
         r_remaining <= w_remaining_next;
         r_in_rdy    <= (w_state_next != SEND);
         r_out_val   <= (w_state_next == SEND);
      end
   end

   assign i_stream_rdy  = r_in_rdy;
   assign o_stream_val  = r_out_val;
   assign o_stream_data = r_sum;

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench for stream_accumulator with hand-computed frame sums.
module tb_stream_accumulator;

   logic        clk;
   logic        reset;
   logic        i_val;
   logic [31:0] i_data;
   logic        w_in_rdy;
   logic        w_out_val;
   logic [31:0] w_out_data;
   logic        o_rdy;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int out_cnt  = 0;
   int waits;

   stream_accumulator #(
      .BIT_WIDTH   (32),
      .COUNT_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_stream_val  (i_val),
      .i_stream_data (i_data),
      .i_stream_rdy  (w_in_rdy),
      .o_stream_val  (w_out_val),
      .o_stream_data (w_out_data),
      .o_stream_rdy  (o_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset && w_out_val && o_rdy) out_cnt <= out_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
         $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
      end else begin
         $display("FAIL %-16s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   // Present one word and hold it until accepted; returns the cycles spent waiting.
   task automatic push(input logic [31:0] d, output int n);
      n = 0;
      i_val  = 1'b1;
      i_data = d;
      while (!w_in_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      i_val = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [31:0] exp);
      int n;
      n = 0;
      while (!w_out_val && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check(tag, w_out_data, exp);
         o_rdy = 1'b1;
         @(posedge clk);
         #1;
         o_rdy = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b0;
      i_val  = 1'b0;
      i_data = '0;
      o_rdy  = 1'b0;
      #12;
      check("rst_in_rdy", {31'd0, w_in_rdy}, 32'd0);
      check("rst_out_val", {31'd0, w_out_val}, 32'd0);
      check("rst_out_data", w_out_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("idle_in_rdy", {31'd0, w_in_rdy}, 32'd1);

      // Basic frame: 5+7+9
      push(32'd3, waits);
      push(32'd5, waits);
      push(32'd7, waits);
      push(32'd9, waits);
      check("basic_val_lat", {31'd0, w_out_val}, 32'd1);
      check("basic_in_rdy", {31'd0, w_in_rdy}, 32'd0);
      pop("basic_sum", 32'h15);
      check("basic_val_drop", {31'd0, w_out_val}, 32'd0);

      // Wrap-around and upper header bits ignored
      push(32'd2, waits);
      push(32'hFFFF_FFFF, waits);
      push(32'h0000_0003, waits);
      pop("wrap_sum", 32'h2);
      push(32'hABCD_0001, waits);
      push(32'h10, waits);
      pop("hdr_upper", 32'h10);

      // Zero count, then next header accepted right after the output transfer
      push(32'd0, waits);
      check("zero_val", {31'd0, w_out_val}, 32'd1);
      check("zero_data", w_out_data, 32'd0);
      pop("zero_sum", 32'd0);
      check("zero_rdy_after", {31'd0, w_in_rdy}, 32'd1);
      push(32'd1, waits);
      check("zero_next_wait", waits, 32'd0);
      push(32'h33, waits);
      pop("zero_next_sum", 32'h33);

      // Input gaps, then output backpressure
      push(32'd2, waits);
      push(32'd1, waits);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("gap_in_rdy", {31'd0, w_in_rdy}, 32'd1);
         check("gap_out_val", {31'd0, w_out_val}, 32'd0);
      end
      push(32'd2, waits);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_val", {31'd0, w_out_val}, 32'd1);
         check("bp_data", w_out_data, 32'd3);
         check("bp_in_rdy", {31'd0, w_in_rdy}, 32'd0);
      end
      pop("bp_sum", 32'd3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_single", {31'd0, w_out_val}, 32'd0);
      end

      // Asynchronous reset mid-frame discards the partial sum
      push(32'd4, waits);
      push(32'd10, waits);
      push(32'd20, waits);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_in_rdy", {31'd0, w_in_rdy}, 32'd0);
      check("mid_rst_val", {31'd0, w_out_val}, 32'd0);
      check("mid_rst_data", w_out_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      push(32'd1, waits);
      push(32'd7, waits);
      pop("post_rst_sum", 32'd7);

      // Maximum count frame followed by a short frame
      push(32'd255, waits);
      for (int k = 0; k < 255; k++) push(32'd1, waits);
      check("max_val", {31'd0, w_out_val}, 32'd1);
      pop("max_sum", 32'hFF);
      push(32'd1, waits);
      push(32'h55, waits);
      pop("after_max_sum", 32'h55);

      repeat (3) @(negedge clk);
      check("out_count", out_cnt, 32'd9);
      check("end_out_val", {31'd0, w_out_val}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
